// File: rtl/demux_router_8bit_pkg.sv
// rtl/demux_router_8bit_pkg.sv - shared widths, channel encodings and pointer-width helper
package demux_router_8bit_pkg;

   localparam int DATA_W_DEF = 8;

   localparam logic CH0 = 1'b0;
   localparam logic CH1 = 1'b1;

   // Smallest r with 2**r >= v; used to size FIFO pointers.
   function automatic int log2c(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/demux_router_8bit_if.sv
// rtl/demux_router_8bit_if.sv - source and two destination handshake bundle
interface demux_router_8bit_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] in_data;
   logic              in_sel;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] out0_data;
   logic              out0_valid;
   logic              out0_ready;
   logic [DATA_W-1:0] out1_data;
   logic              out1_valid;
   logic              out1_ready;

   modport master (
      output in_data, in_sel, in_valid, out0_ready, out1_ready,
      input  in_ready, out0_data, out0_valid, out1_data, out1_valid
   );

   modport slave (
      input  in_data, in_sel, in_valid, out0_ready, out1_ready,
      output in_ready, out0_data, out0_valid, out1_data, out1_valid
   );
endinterface

// File: rtl/demux_router_8bit_sync_fifo.sv
// rtl/demux_router_8bit_sync_fifo.sv - register FIFO with guarded push/pop and combinational head
module sync_fifo_8bit
   import demux_router_8bit_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] wdata,
   input  logic              pop,
   output logic [DATA_W-1:0] head,
   output logic              full,
   output logic              empty
);
   localparam int PTR_W = log2c(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wptr;
   logic [PTR_W-1:0]  rptr;
   logic [PTR_W:0]    count;
   logic              push_en;
   logic              pop_en;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign push_en = push && !full;
   assign pop_en  = pop && !empty;
   assign head    = mem[rptr];

   // Storage is cleared on reset so an empty FIFO presents a zero head word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push_en) begin
            mem[wptr] <= wdata;
            wptr      <= wptr + 1'b1;
         end
         if (pop_en) rptr <= rptr + 1'b1;
         case ({push_en, pop_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/demux_router_8bit.sv
// rtl/demux_router_8bit.sv - steers one source stream into two buffered destinations with counters
module demux_router_8bit
   import demux_router_8bit_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   demux_router_8bit_if.slave bus,
   output logic [CNT_W-1:0]  cnt0,
   output logic [CNT_W-1:0]  cnt1
);
   logic full0, full1, empty0, empty1;
   logic accept, push0, push1;

   // Ready looks only at the selected FIFO's full flag, never at valid or pop.
   assign bus.in_ready = !rst && !((bus.in_sel == CH1) ? full1 : full0);
   assign accept       = bus.in_valid && bus.in_ready;
   assign push0        = accept && (bus.in_sel == CH0);
   assign push1        = accept && (bus.in_sel == CH1);

   assign bus.out0_valid = !empty0;
   assign bus.out1_valid = !empty1;

   sync_fifo_8bit #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo0 (
      .clk   (clk),
      .rst   (rst),
      .push  (push0),
      .wdata (bus.in_data),
      .pop   (bus.out0_ready),
      .head  (bus.out0_data),
      .full  (full0),
      .empty (empty0)
   );

   sync_fifo_8bit #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo1 (
      .clk   (clk),
      .rst   (rst),
      .push  (push1),
      .wdata (bus.in_data),
      .pop   (bus.out1_ready),
      .head  (bus.out1_data),
      .full  (full1),
      .empty (empty1)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt0 <= '0;
         cnt1 <= '0;
      end else begin
         if (push0) cnt0 <= cnt0 + 1'b1;
         if (push1) cnt1 <= cnt1 + 1'b1;
      end
   end
endmodule

// File: tb/tb_demux_router_8bit.sv
// tb/tb_demux_router_8bit.sv - directed self-checking bench for demux_router_8bit
module tb_demux_router_8bit;
   logic       clk;
   logic       rst;
   logic [7:0] cnt0;
   logic [7:0] cnt1;
   int         checks;
   int         errors;
   logic [7:0] exp_q [4];

   demux_router_8bit_if #(.DATA_W(8)) bus ();

   demux_router_8bit #(.DATA_W(8), .DEPTH(4), .CNT_W(8)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .cnt0 (cnt0),
      .cnt1 (cnt1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus.in_data    = 8'h00;
      bus.in_sel     = 1'b0;
      bus.in_valid   = 1'b0;
      bus.out0_ready = 1'b0;
      bus.out1_ready = 1'b0;
      #1;
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_out0_valid", bus.out0_valid, 0);
      chk("rst_out1_valid", bus.out1_valid, 0);
      chk("rst_out0_data", bus.out0_data, 8'h00);
      chk("rst_out1_data", bus.out1_data, 8'h00);
      chk("rst_cnt0", cnt0, 0);
      chk("rst_cnt1", cnt1, 0);
      tick();
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", bus.in_ready, 1);

      // Routing
      bus.out0_ready = 1'b1;
      bus.out1_ready = 1'b1;
      bus.in_data = 8'h11; bus.in_sel = 1'b0; bus.in_valid = 1'b1;
      #1;
      chk("route_no_comb_path", bus.out0_valid, 0);
      tick();
      chk("route_out0_valid", bus.out0_valid, 1);
      chk("route_out0_data", bus.out0_data, 8'h11);
      chk("route_cnt0", cnt0, 1);
      bus.in_data = 8'h22; bus.in_sel = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      chk("route_out1_valid", bus.out1_valid, 1);
      chk("route_out1_data", bus.out1_data, 8'h22);
      chk("route_cnt1", cnt1, 1);
      chk("route_out0_popped", bus.out0_valid, 0);
      tick();
      chk("route_out1_popped", bus.out1_valid, 0);

      // Backpressure on channel 0, channel 1 keeps flowing
      bus.out0_ready = 1'b0;
      bus.in_sel = 1'b0; bus.in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.in_data = 8'hA0 + 8'(i);
         #1;
         chk("bp_in_ready_fill", bus.in_ready, 1);
         tick();
      end
      chk("bp_full_in_ready", bus.in_ready, 0);
      chk("bp_cnt0", cnt0, 5);
      chk("bp_head_stable", bus.out0_data, 8'hA0);
      bus.in_sel = 1'b1; bus.in_data = 8'hB0;
      #1;
      chk("bp_indep_in_ready", bus.in_ready, 1);
      tick();
      bus.in_valid = 1'b0;
      chk("bp_out1_valid", bus.out1_valid, 1);
      chk("bp_out1_data", bus.out1_data, 8'hB0);
      chk("bp_cnt1", cnt1, 2);
      bus.out0_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("bp_drain_valid", bus.out0_valid, 1);
         chk("bp_drain_data", bus.out0_data, 8'hA0 + 8'(i));
         tick();
      end
      chk("bp_drain_empty", bus.out0_valid, 0);

      // Full with simultaneous pop: push refused that edge
      bus.out0_ready = 1'b0;
      bus.in_sel = 1'b0; bus.in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.in_data = 8'hC0 + 8'(i);
         tick();
      end
      bus.out0_ready = 1'b1;
      bus.in_data = 8'hD0;
      #1;
      chk("fp_in_ready_full", bus.in_ready, 0);
      tick();
      chk("fp_cnt0_no_push", cnt0, 9);
      chk("fp_head_after_pop", bus.out0_data, 8'hC1);
      chk("fp_in_ready_room", bus.in_ready, 1);
      bus.out0_ready = 1'b0;
      tick();
      bus.in_valid = 1'b0;
      chk("fp_cnt0_push", cnt0, 10);
      chk("fp_full_again", bus.in_ready, 0);
      exp_q[0] = 8'hC1; exp_q[1] = 8'hC2; exp_q[2] = 8'hC3; exp_q[3] = 8'hD0;
      bus.out0_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("fp_drain_data", bus.out0_data, exp_q[i]);
         tick();
      end
      chk("fp_drain_empty", bus.out0_valid, 0);

      // Counter wrap on channel 1: it starts at 2, 253 pushes reach 0xFF
      bus.out1_ready = 1'b1;
      bus.in_sel = 1'b1; bus.in_valid = 1'b1;
      for (int i = 0; i < 253; i++) begin
         bus.in_data = 8'(i);
         tick();
      end
      chk("wrap_cnt1_max", cnt1, 8'hFF);
      tick();
      chk("wrap_cnt1_zero", cnt1, 8'h00);
      tick();
      tick();
      bus.in_valid = 1'b0;
      chk("wrap_cnt1_256", cnt1, 8'h02);
      chk("wrap_cnt0_same", cnt0, 10);
      tick();

      // Reset mid-stream with 3 words buffered in channel 0
      bus.out0_ready = 1'b0;
      bus.in_sel = 1'b0; bus.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.in_data = 8'h31 + 8'(i);
         tick();
      end
      bus.in_valid = 1'b0;
      chk("mid_out0_valid", bus.out0_valid, 1);
      #2 rst = 1'b1;
      #1;
      chk("async_in_ready", bus.in_ready, 0);
      chk("async_out0_valid", bus.out0_valid, 0);
      chk("async_out0_data", bus.out0_data, 8'h00);
      chk("async_cnt0", cnt0, 0);
      chk("async_cnt1", cnt1, 0);
      #2 rst = 1'b0;
      bus.in_data = 8'h5A; bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      chk("mid_new_valid", bus.out0_valid, 1);
      chk("mid_new_data", bus.out0_data, 8'h5A);
      chk("mid_new_cnt0", cnt0, 1);
      bus.out0_ready = 1'b1;
      tick();
      chk("mid_no_stale", bus.out0_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/demux_router_8bit.md
Name: demux_router_8bit

Overview:
- Reverse direction of the 2:1 8-bit selection path: one 8-bit source stream is steered to one of two 8-bit destinations.
- Sits between the shared sample bus and the two per-channel consumers of the health-checking datapath, e.g. vital-sign processing units.
- Each destination has its own small FIFO and valid/ready handshake, so one stalled consumer never corrupts data for the other.
- Per-channel accepted-byte counters are kept for status readout.

Parameters:
- DATA_W, 8, width of a data word.
- DEPTH, 4, entries per output FIFO; power of two, minimum 2.
- CNT_W, 8, width of each accepted-word counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_data  input  DATA_W  word from the shared source.
- in_sel  input  1  destination select: 0 = channel 0, 1 = channel 1.
- in_valid  input  1  source presents a word.
- in_ready  output  1  selected destination can accept.
- out0_data  output  DATA_W  channel-0 head word.
- out0_valid  output  1  channel-0 FIFO non-empty.
- out0_ready  input  1  channel-0 consumer takes the word.
- out1_data  output  DATA_W  channel-1 head word.
- out1_valid  output  1  channel-1 FIFO non-empty.
- out1_ready  input  1  channel-1 consumer takes the word.
- cnt0  output  CNT_W  words accepted for channel 0.
- cnt1  output  CNT_W  words accepted for channel 1.

Interface decision (fixed): one clock, clk; reset rst is asynchronous and active-high.

Behaviour:

Reset (rst high, asynchronous):
- Both FIFOs are emptied: pointers and occupancy go to 0.
- out0_valid = out1_valid = 0.
- cnt0 = cnt1 = 0.
- out0_data and out1_data = 0.
- in_ready = 0 while rst is high.
- Asserting rst mid-operation discards all buffered words immediately. Nothing is replayed after release.

Input handshake:
- in_ready = !rst && !full[in_sel]. It is combinational from in_sel and FIFO state only, never from in_valid.
- Accept occurs on a rising edge where in_valid && in_ready. The word is pushed into FIFO[in_sel] and cnt[in_sel] increments.
- in_sel is meaningful only on accept cycles.

Output handshake:
- outX_valid = !emptyX.
- outX_data = entry at the FIFO read pointer, read combinationally from registers. It must be stable while outX_valid && !outX_ready.
- Pop occurs on an edge where outX_valid && outX_ready.
- outX_ready while outX_valid = 0 has no effect.

Latency:
- A word accepted at edge N is visible on outX_valid/outX_data after edge N, i.e. in the next cycle.
- There is no combinational path from input to output.

Boundary conditions:
- Full: no push is allowed when full, even if a pop happens on the same edge. in_ready stays low, so there is no ready-depends-on-ready path.
- Not full: push and pop on the same edge are both performed and occupancy is unchanged.
- Empty: pop is ignored, and occupancy never underflows.
- Independence: a full channel 0 with in_sel = 1 leaves in_ready high, so channel 1 traffic continues.
- Pointers: the write and read pointers wrap modulo DEPTH. Occupancy is tracked with a log2(DEPTH)+1-bit counter.
- Counters: cntX wraps from 2^CNT_W-1 to 0 and is not saturating.

Decomposition:
- Shared package/header holds:
  - DATA_W default.
  - The CH0/CH1 select encodings (0/1).
  - A log2 helper constant function for pointer widths.
- The natural sub-module is sync_fifo_8bit, instantiated twice.
  - It is a parameterised DEPTH register FIFO with push/pop/full/empty/head and async active-high reset.
- Top level contains only:
  - Select decode.
  - in_ready generation.
  - The two counters.

Test Plan:
1. Reset check: assert rst asynchronously mid-cycle -> in_ready, out0_valid, out1_valid and both counters go to 0 immediately, without waiting for a clock edge.
2. Routing: send 0x11 (sel=0) then 0x22 (sel=1) with both readies high -> out0 shows 0x11 one cycle after its accept, out1 shows 0x22 one cycle after its accept; cnt0 = 1, cnt1 = 1.
3. Backpressure: out0_ready = 0, push 0xA0..0xA3 on channel 0 -> in_ready drops once 4 words are held. Then push 0xB0 on channel 1 -> accepted, and out1 shows 0xB0. Then raise out0_ready -> 0xA0, 0xA1, 0xA2, 0xA3 drain in order.
4. Full with simultaneous pop: with channel 0 full and out0_ready = 1, in_valid with sel=0 -> no push that cycle. The push succeeds the following cycle, and occupancy returns to 4.
5. Counter wrap: push 256 words to channel 1 with out1_ready = 1 -> cnt1 = 0 and cnt0 unchanged.
6. Reset mid-stream: with 3 words buffered in channel 0, pulse rst -> out0_valid = 0 after reset. Next push 0x5A -> out0_data = 0x5A, with no stale words ahead of it.
